// File: rtl/conv_output_streamer.sv
// conv_output_streamer: walks the flat convolution result bus one word per
// accepted valid/ready beat, highest index first (channel D-1, row H-1,
// col W-1 down to 0). The bus is assumed stable while a frame is in flight;
// only the current word is registered, the bus itself is never stored.
// Optional build macro CONV_STREAM_COORD_EN adds out_ch/out_row/out_col
// coordinate outputs aligned with out_data.
module conv_output_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 6,
  parameter int H          = 28,
  parameter int W          = 28
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [D*H*W*DATA_WIDTH-1:0]  conv_out,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
`ifdef CONV_STREAM_COORD_EN
  ,
  output logic [((D > 1) ? $clog2(D) : 1)-1:0] out_ch,
  output logic [((H > 1) ? $clog2(H) : 1)-1:0] out_row,
  output logic [((W > 1) ? $clog2(W) : 1)-1:0] out_col
`endif
);

  localparam int N    = D * H * W;
  localparam int CW   = (D > 1) ? $clog2(D) : 1;
  localparam int RW   = (H > 1) ? $clog2(H) : 1;
  localparam int LW   = (W > 1) ? $clog2(W) : 1;
  localparam int IW   = ((N * DATA_WIDTH) > 1) ? $clog2(N * DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CH_MAX  = CW'(D - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
  localparam logic [LW-1:0] COL_MAX = LW'(W - 1);

  // Bit strides of one channel / row / column inside the flat bus. Products
  // are taken modulo 2^IW; every real bit offset is below 2^IW so the sum
  // stays exact even if a stride constant itself wraps.
  localparam logic [IW-1:0] CH_STRIDE  = IW'(H * W * DATA_WIDTH);
  localparam logic [IW-1:0] ROW_STRIDE = IW'(W * DATA_WIDTH);
  localparam logic [IW-1:0] COL_STRIDE = IW'(DATA_WIDTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [RW-1:0]         row_q, row_d;
  logic [LW-1:0]         col_q, col_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  load;
  logic                  at_zero;
  logic [IW-1:0]         bit_idx;

  // Next-state, coordinate down-counting and registered word select.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    bit_idx = '0;
    at_zero = (ch_q == '0) && (row_q == '0) && (col_q == '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          ch_d    = CH_MAX;
          row_d   = ROW_MAX;
          col_d   = COL_MAX;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (valid_q && out_ready) begin
          if (at_zero) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            if (col_q == '0) begin
              col_d = COL_MAX;
              if (row_q == '0) begin
                row_d = ROW_MAX;
                ch_d  = ch_q - 1'b1;
              end else begin
                row_d = row_q - 1'b1;
              end
            end else begin
              col_d = col_q - 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new word is presented only on start or after a beat; last marks the
    // word at coordinate (0,0,0).
    if (load) begin
      bit_idx = IW'(ch_d) * CH_STRIDE + IW'(row_d) * ROW_STRIDE + IW'(col_d) * COL_STRIDE;
      data_d  = conv_out[bit_idx +: DATA_WIDTH];
      last_d  = (ch_d == '0) && (row_d == '0) && (col_d == '0);
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q == STREAM);
  assign done      = done_q;

`ifdef CONV_STREAM_COORD_EN
  assign out_ch  = ch_q;
  assign out_row = row_q;
  assign out_col = col_q;
`endif

endmodule

// File: tb/tb_conv_output_streamer.sv
// Bench for conv_output_streamer: a table of frame scenarios on the default
// 6x28x28 build, a scoreboard queue of expected words, and a hand-written
// sequence on a 1x1x1 build. Coordinate checks compile in with
// CONV_STREAM_COORD_EN.
module tb_conv_output_streamer;

  localparam int DW = 32;
  localparam int D  = 6;
  localparam int H  = 28;
  localparam int W  = 28;
  localparam int N  = D * H * W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [N*DW-1:0]   conv_out;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  logic              start1;
  logic [DW-1:0]     conv_out1;
  logic [DW-1:0]     out_data1;
  logic              out_valid1;
  logic              out_ready1;
  logic              out_last1;
  logic              busy1;
  logic              done1;

`ifdef CONV_STREAM_COORD_EN
  logic [2:0] out_ch;
  logic [4:0] out_row;
  logic [4:0] out_col;
  logic       out_ch1;
  logic       out_row1;
  logic       out_col1;
`endif

  conv_output_streamer #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .conv_out(conv_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef CONV_STREAM_COORD_EN
    , .out_ch(out_ch), .out_row(out_row), .out_col(out_col)
`endif
  );

  conv_output_streamer #(.DATA_WIDTH(DW), .D(1), .H(1), .W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .conv_out(conv_out1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .busy(busy1), .done(done1)
`ifdef CONV_STREAM_COORD_EN
    , .out_ch(out_ch1), .out_row(out_row1), .out_col(out_col1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            k;
  } exp_t;

  typedef struct {
    string         name;
    int            pat;
    int            ready_pct;
    bit            glitch;
    int            abort_at;
    bit            chain;
    logic [DW-1:0] first;
  } vec_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;
  int   cur_pat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int pat, input int k);
    if (pat == 0) return 32'h43C80000;
    return DW'(k);
  endfunction

  task automatic load_bus(input int pat);
    cur_pat = pat;
    for (int k = 0; k < N; k++) conv_out[k*DW +: DW] = word_of(pat, k);
  endtask

  task automatic run_frame(input string nm, input int ready_pct, input bit do_start,
                           input bit glitch, input int abort_at, input bit chain,
                           input logic [DW-1:0] first);
    exp_t          e;
    int            beats;
    int            cyc;
    bit            stalled;
    logic [DW-1:0] pd;
    logic          pl;
    for (int k = N - 1; k >= 0; k--) begin
      e.data = word_of(cur_pat, k);
      e.last = (k == 0);
      e.k    = k;
      sb.push_back(e);
    end
    if (do_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_first_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_first_word"}, 64'(out_data), 64'(first));
    beats   = 0;
    cyc     = 0;
    stalled = 1'b0;
    pd      = '0;
    pl      = 1'b0;
    while (beats < N) begin
      if (cyc > 4 * N + 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: got %0d beats expected %0d", nm, beats, N);
        sb.delete();
        return;
      end
      cyc++;
      if (stalled) begin
        chk({nm, "_stall_data"}, 64'(out_data), 64'(pd));
        chk({nm, "_stall_last"}, 64'(out_last), 64'(pl));
      end
      chk({nm, "_valid_busy"}, 64'({out_valid, busy}), 64'b11);
      out_ready = ($urandom_range(99) < ready_pct);
      start     = glitch && (beats == 10 || beats == 500);
      if (out_ready && out_valid) begin
        e = sb.pop_front();
        chk({nm, "_data"}, 64'(out_data), 64'(e.data));
        chk({nm, "_last"}, 64'(out_last), 64'(e.last));
`ifdef CONV_STREAM_COORD_EN
        chk({nm, "_coord"}, 64'({out_ch, out_row, out_col}),
            64'({3'(e.k / (H * W)), 5'((e.k / W) % H), 5'(e.k % W)}));
`endif
        beats++;
      end
      stalled = !out_ready;
      pd      = out_data;
      pl      = out_last;
      @(posedge clk); #1;
      start = 1'b0;
      if (abort_at > 0 && beats == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_rst_outs"}, 64'({out_data, out_valid, out_last, busy, done}), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_rst_nodone"}, 64'({out_valid, done}), 64'd0);
        sb.delete();
        return;
      end
    end
    if (ready_pct == 100) chk({nm, "_frame_cycles"}, 64'(cyc), 64'(N));
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({nm, "_done"}, 64'({done, out_valid, out_last, busy}), 64'b1000);
    if (chain) begin
      start = 1'b1;
      return;
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    cur_pat   = 0;
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    conv_out  = '0;
    start1    = 1'b0;
    out_ready1 = 1'b0;
    conv_out1 = '0;

    vecs[0] = '{"const400",   0, 100, 1'b0, 0,    1'b0, 32'h43C80000};
    vecs[1] = '{"index",      1, 100, 1'b0, 0,    1'b0, 32'h0000125F};
    vecs[2] = '{"rand_ready", 1, 50,  1'b0, 0,    1'b0, 32'h0000125F};
    vecs[3] = '{"start_glt",  1, 100, 1'b1, 0,    1'b1, 32'h0000125F};
    vecs[4] = '{"reset_mid",  1, 100, 1'b0, 1000, 1'b0, 32'h0000125F};
    vecs[5] = '{"restart",    1, 100, 1'b0, 0,    1'b0, 32'h0000125F};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'({out_data, out_valid, out_last, busy, done}), 64'd0);
    chk("reset_outs1", 64'({out_data1, out_valid1, out_last1, busy1, done1}), 64'd0);
`ifdef CONV_STREAM_COORD_EN
    chk("reset_coord", 64'({out_ch, out_row, out_col}), 64'd0);
`endif
    reset = 1'b0;

    // Ready while idle must not produce anything.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 64'({out_valid, busy, done}), 64'd0);
    out_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load_bus(vecs[i].pat);
      run_frame(vecs[i].name, vecs[i].ready_pct, 1'b1, vecs[i].glitch,
                vecs[i].abort_at, vecs[i].chain, vecs[i].first);
      if (vecs[i].chain) run_frame("chained", 100, 1'b0, 1'b0, 0, 1'b0, 32'h0000125F);
    end

    // Single-word frame, first stalled for one cycle.
    conv_out1 = 32'hDEADBEEF;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("n1_first", 64'({out_valid1, out_last1, busy1, out_data1}), 64'({3'b111, 32'hDEADBEEF}));
    @(posedge clk); #1;
    chk("n1_stall", 64'({out_valid1, out_last1, done1, out_data1}), 64'({3'b110, 32'hDEADBEEF}));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    chk("n1_done", 64'({out_valid1, out_last1, busy1, done1}), 64'b0001);
    @(posedge clk); #1;
    chk("n1_done_pulse", 64'(done1), 64'd0);
    out_ready1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
